// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and types for the two-source register-file writeback arbiter.
package wb_port_arbiter_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

endpackage : wb_port_arbiter_pkg

// File: rtl/wb_port_arbiter_if.sv
// Writeback bus: two valid/ready request ports in, one register-file write port out.
interface wb_port_arbiter_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  import wb_port_arbiter_pkg::*;

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_wd;
  logic                  alu_ready;

  logic                  lsu_valid;
  logic [REG_ADDR_W-1:0] lsu_rd;
  logic [XLEN-1:0]       lsu_wd;
  logic                  lsu_ready;

  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_rd;
  logic [XLEN-1:0]       rf_wd;
  logic                  last_src;
  logic [CNT_W-1:0]      contention_cnt;

  // Requester side: drives requests, observes grants and the write port.
  modport master (
    output alu_valid, alu_rd, alu_wd,
    output lsu_valid, lsu_rd, lsu_wd,
    input  alu_ready, lsu_ready,
    input  rf_we, rf_rd, rf_wd, last_src, contention_cnt
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_rd, alu_wd,
    input  lsu_valid, lsu_rd, lsu_wd,
    output alu_ready, lsu_ready,
    output rf_we, rf_rd, rf_wd, last_src, contention_cnt
  );

endinterface : wb_port_arbiter_if

// File: rtl/wb_port_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, on contention the
// pointer decides, and the pointer moves to the loser after every grant.
module rr_arb2
  import wb_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt_c
);

  wb_src_e ptr_q;
  wb_src_e ptr_d;

  // Grant is forced low while in reset so nothing is accepted.
  always_comb begin
    gnt_c = 2'b00;
    ptr_d = ptr_q;
    if (rst_n) begin
      unique case (req)
        2'b01:   gnt_c = 2'b01;
        2'b10:   gnt_c = 2'b10;
        2'b11:   gnt_c = (ptr_q == SRC_ALU) ? 2'b01 : 2'b10;
        default: gnt_c = 2'b00;
      endcase
    end
    if (gnt_c[0]) begin
      ptr_d = SRC_LSU;
    end else if (gnt_c[1]) begin
      ptr_d = SRC_ALU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= SRC_ALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule : rr_arb2

// File: rtl/wb_port_arbiter.sv
// Arbitrates ALU and LSU writebacks onto one registered register-file write
// port and counts contention cycles.
module wb_port_arbiter #(
  parameter int unsigned XLEN  = wb_port_arbiter_pkg::XLEN,
  parameter int unsigned CNT_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  wb_port_arbiter_if.slave  bus
);
  import wb_port_arbiter_pkg::*;

  logic [1:0]            req;
  logic [1:0]            gnt_c;

  logic                  rf_we_q,    rf_we_d;
  logic [REG_ADDR_W-1:0] rf_rd_q,    rf_rd_d;
  logic [XLEN-1:0]       rf_wd_q,    rf_wd_d;
  wb_src_e               last_src_q, last_src_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;

  assign req = {bus.lsu_valid, bus.alu_valid};

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt_c (gnt_c)
  );

  assign bus.alu_ready = gnt_c[0];
  assign bus.lsu_ready = gnt_c[1];

  // Capture the granted request; writes to x0 are accepted but suppressed.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wd_d    = rf_wd_q;
    last_src_d = last_src_q;
    cnt_d      = cnt_q;
    if (gnt_c[1]) begin
      rf_rd_d    = bus.lsu_rd;
      rf_wd_d    = bus.lsu_wd;
      last_src_d = SRC_LSU;
    end else if (gnt_c[0]) begin
      rf_rd_d    = bus.alu_rd;
      rf_wd_d    = bus.alu_wd;
      last_src_d = SRC_ALU;
    end
    rf_we_d = (|gnt_c) && (rf_rd_d != REG_ADDR_W'(0));
    if (bus.alu_valid && bus.lsu_valid && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wd_q    <= '0;
      last_src_q <= SRC_ALU;
      cnt_q      <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wd_q    <= rf_wd_d;
      last_src_q <= last_src_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.rf_we          = rf_we_q;
  assign bus.rf_rd          = rf_rd_q;
  assign bus.rf_wd          = rf_wd_q;
  assign bus.last_src       = last_src_q;
  assign bus.contention_cnt = cnt_q;

endmodule : wb_port_arbiter

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter.
module tb_wb_port_arbiter;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned SAT_CYCLES = (1 << CNT_W) + 3;
  localparam logic [63:0] CNT_MAX = 64'((1 << CNT_W) - 1);

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  wb_port_arbiter_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  wb_port_arbiter #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] wd);
    bus.alu_valid = v;
    bus.alu_rd    = rd;
    bus.alu_wd    = wd;
  endtask

  task automatic set_lsu(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] wd);
    bus.lsu_valid = v;
    bus.lsu_rd    = rd;
    bus.lsu_wd    = wd;
  endtask

  initial begin
    logic [4:0]      a_rd, l_rd, e_rd;
    logic [XLEN-1:0] a_wd, l_wd, e_wd;
    logic            e_lsu;
    logic [63:0]     e_cnt;

    n_checks = 0;
    n_errors = 0;

    // Reset held with both requests asserted: nothing granted, outputs cleared
    rst_n = 1'b0;
    set_alu(1'b1, 5'd3, 32'h1);
    set_lsu(1'b1, 5'd4, 32'h2);
    tick();
    tick();
    check("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
    check("rst_lsu_ready", 64'(bus.lsu_ready), 64'd0);
    check("rst_rf_we",     64'(bus.rf_we), 64'd0);
    check("rst_rf_rd",     64'(bus.rf_rd), 64'd0);
    check("rst_rf_wd",     64'(bus.rf_wd), 64'd0);
    check("rst_last_src",  64'(bus.last_src), 64'd0);
    check("rst_cnt",       64'(bus.contention_cnt), 64'd0);

    // Single ALU write, granted on the first edge after release
    rst_n = 1'b1;
    set_alu(1'b1, 5'd5, 32'hDEADBEEF);
    set_lsu(1'b0, 5'd0, 32'h0);
    #1;
    check("alu_only_ready", 64'(bus.alu_ready), 64'd1);
    check("alu_only_lsu_ready", 64'(bus.lsu_ready), 64'd0);
    tick();
    set_alu(1'b0, 5'd0, 32'h0);
    check("alu_only_we", 64'(bus.rf_we), 64'd1);
    check("alu_only_rd", 64'(bus.rf_rd), 64'd5);
    check("alu_only_wd", 64'(bus.rf_wd), 64'hDEADBEEF);
    check("alu_only_src", 64'(bus.last_src), 64'd0);

    // LSU write to x0: accepted, but no register-file write
    set_lsu(1'b1, 5'd0, 32'h1234);
    #1;
    check("x0_lsu_ready", 64'(bus.lsu_ready), 64'd1);
    tick();
    set_lsu(1'b0, 5'd0, 32'h0);
    check("x0_we", 64'(bus.rf_we), 64'd0);
    check("x0_last_src", 64'(bus.last_src), 64'd1);
    check("pre_cont_cnt", 64'(bus.contention_cnt), 64'd0);

    // Four contended cycles, pointer at ALU: ALU, LSU, ALU, LSU back to back
    a_rd = 5'd1; a_wd = 32'hA0;
    l_rd = 5'd2; l_wd = 32'hB0;
    for (int k = 0; k < 4; k++) begin
      e_lsu = (k % 2) == 1;
      set_alu(1'b1, a_rd, a_wd);
      set_lsu(1'b1, l_rd, l_wd);
      e_rd = e_lsu ? l_rd : a_rd;
      e_wd = e_lsu ? l_wd : a_wd;
      #1;
      check($sformatf("rr%0d_alu_ready", k), 64'(bus.alu_ready), 64'(!e_lsu));
      check($sformatf("rr%0d_lsu_ready", k), 64'(bus.lsu_ready), 64'(e_lsu));
      tick();
      check($sformatf("rr%0d_we", k), 64'(bus.rf_we), 64'd1);
      check($sformatf("rr%0d_rd", k), 64'(bus.rf_rd), 64'(e_rd));
      check($sformatf("rr%0d_wd", k), 64'(bus.rf_wd), 64'(e_wd));
      check($sformatf("rr%0d_src", k), 64'(bus.last_src), 64'(e_lsu));
      if (e_lsu) begin
        l_rd = l_rd + 5'd2; l_wd = l_wd + 32'h1;
      end else begin
        a_rd = a_rd + 5'd2; a_wd = a_wd + 32'h1;
      end
    end
    set_alu(1'b0, 5'd0, 32'h0);
    set_lsu(1'b0, 5'd0, 32'h0);
    check("rr_cnt", 64'(bus.contention_cnt), 64'd4);

    // Same destination from both sources: grant order decides final value
    set_alu(1'b1, 5'd7, 32'h11);
    set_lsu(1'b1, 5'd7, 32'h22);
    #1;
    check("same_rd_alu_first", 64'(bus.alu_ready), 64'd1);
    tick();
    set_alu(1'b0, 5'd0, 32'h0);
    check("same_rd_w1_we", 64'(bus.rf_we), 64'd1);
    check("same_rd_w1_wd", 64'(bus.rf_wd), 64'h11);
    #1;
    check("same_rd_lsu_next", 64'(bus.lsu_ready), 64'd1);
    tick();
    set_lsu(1'b0, 5'd0, 32'h0);
    check("same_rd_w2_we", 64'(bus.rf_we), 64'd1);
    check("same_rd_w2_rd", 64'(bus.rf_rd), 64'd7);
    check("same_rd_w2_wd", 64'(bus.rf_wd), 64'h22);
    check("same_rd_cnt", 64'(bus.contention_cnt), 64'd5);

    // Idle cycle: no write, address/data hold
    tick();
    check("idle_we", 64'(bus.rf_we), 64'd0);
    check("idle_rd", 64'(bus.rf_rd), 64'd7);
    check("idle_wd", 64'(bus.rf_wd), 64'h22);
    check("idle_src", 64'(bus.last_src), 64'd1);

    // Asynchronous reset while an accepted write is on the port
    set_alu(1'b1, 5'd9, 32'hCAFE);
    tick();
    set_alu(1'b0, 5'd0, 32'h0);
    check("pre_arst_we", 64'(bus.rf_we), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_we", 64'(bus.rf_we), 64'd0);
    check("arst_rd", 64'(bus.rf_rd), 64'd0);
    check("arst_wd", 64'(bus.rf_wd), 64'd0);
    check("arst_src", 64'(bus.last_src), 64'd0);
    check("arst_cnt", 64'(bus.contention_cnt), 64'd0);
    tick();
    check("arst_edge_we", 64'(bus.rf_we), 64'd0);

    // Release with both valid: pointer back at ALU; counter saturates
    rst_n = 1'b1;
    set_alu(1'b1, 5'd3, 32'h1);
    set_lsu(1'b1, 5'd4, 32'h2);
    for (int i = 0; i < SAT_CYCLES; i++) begin
      #1;
      if (i == 0) begin
        check("post_rst_alu_ready", 64'(bus.alu_ready), 64'd1);
      end
      check($sformatf("sat%0d_one_grant", i), 64'(bus.alu_ready ^ bus.lsu_ready), 64'd1);
      tick();
      e_cnt = (64'(i + 1) > CNT_MAX) ? CNT_MAX : 64'(i + 1);
      if (i == 0) begin
        check("post_rst_we", 64'(bus.rf_we), 64'd1);
        check("post_rst_rd", 64'(bus.rf_rd), 64'd3);
      end
      if (i == 0 || i == SAT_CYCLES - 5 || i == SAT_CYCLES - 4 || i == SAT_CYCLES - 1) begin
        check($sformatf("sat%0d_cnt", i), 64'(bus.contention_cnt), e_cnt);
      end
    end
    set_alu(1'b0, 5'd0, 32'h0);
    set_lsu(1'b0, 5'd0, 32'h0);
    tick();
    check("sat_hold_cnt", 64'(bus.contention_cnt), CNT_MAX);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_wb_port_arbiter

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the write-data width.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the contention-counter width.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 alu_valid  input  1  ALU writeback request.
REQ-007 alu_rd  input  5  ALU destination register.
REQ-008 alu_wd  input  XLEN  ALU write data.
REQ-009 alu_ready  output  1  ALU request accepted this cycle.
REQ-010 lsu_valid  input  1  LSU writeback request.
REQ-011 lsu_rd  input  5  LSU destination register.
REQ-012 lsu_wd  input  XLEN  LSU write data.
REQ-013 lsu_ready  output  1  LSU request accepted this cycle.
REQ-014 rf_we  output  1  register-file write enable, registered.
REQ-015 rf_rd  output  5  register-file write address, registered.
REQ-016 rf_wd  output  XLEN  register-file write data, registered.
REQ-017 last_src  output  1  source of the most recent accepted request (0 = ALU, 1 = LSU).
REQ-018 contention_cnt  output  CNT_W  saturating count of cycles with both requests valid.

Function
REQ-019 A transfer SHALL occur on a rising edge where valid and ready are both 1 for a source.
REQ-020 At most one source SHALL be granted per cycle; alu_ready and lsu_ready SHALL never both be 1.
REQ-021 ready SHALL be combinational from the valid inputs and the priority pointer, and SHALL NOT depend on its own source's data.
REQ-022 Only one valid source: that source SHALL be granted in the same cycle, regardless of the pointer.
REQ-023 Both sources valid: the source named by the priority pointer SHALL be granted.
REQ-024 After any transfer, the pointer SHALL point to the non-granted source; with no transfer, it SHALL hold.
REQ-025 A requester SHALL hold valid, rd and wd stable until it is granted; the bench flags violations as protocol errors and does not check DUT output for them.
REQ-026 A transfer in cycle N SHALL drive rf_we/rf_rd/rf_wd with the accepted rd/wd in cycle N+1 (latency 1).
REQ-027 A transfer with rd = 0 SHALL be accepted, but rf_we SHALL be 0 in cycle N+1.
REQ-028 With no transfer in cycle N, rf_we SHALL be 0 in cycle N+1, and rf_rd/rf_wd SHALL hold their previous values.
REQ-029 Sustained throughput SHALL be one write per cycle with no bubbles while any valid is high.
REQ-030 Both sources valid with the same rd: writes SHALL be issued in grant order; the later write overwrites the earlier.
REQ-031 last_src SHALL update on each transfer and hold otherwise.
REQ-032 contention_cnt SHALL increment in each cycle where alu_valid and lsu_valid are both 1, and saturate at all-ones.

Reset
REQ-033 While rst_n = 0: rf_we = 0, rf_rd = 0, rf_wd = 0, last_src = 0, contention_cnt = 0, pointer = ALU.
REQ-034 alu_ready and lsu_ready SHALL be 0 while rst_n = 0.
REQ-035 Reset assertion SHALL take effect immediately, without waiting for a clock edge.
REQ-036 Reset assertion SHALL discard any accepted-but-unwritten request without writing it.
REQ-037 Reset release SHALL be synchronised externally; the first grant SHALL be possible on the first edge after release.

Structure
REQ-038 The shared package SHALL hold XLEN, REG_ADDR_W = 5, and the wb_src_e enum (SRC_ALU = 0, SRC_LSU = 1).
REQ-039 The 2-way grant and pointer logic SHALL be one sub-module, rr_arb2; output registers and the counter SHALL stay in wb_port_arbiter.

Verification
REQ-040 Reset, then alu_valid = 1, rd = 5, wd = 0xDEADBEEF -> alu_ready = 1 same cycle; next cycle rf_we = 1, rf_rd = 5, rf_wd = 0xDEADBEEF.
REQ-041 Both valid for 4 cycles (each new request presented after its grant) -> grants ALU, LSU, ALU, LSU; writes back-to-back; contention_cnt = 4.
REQ-042 lsu_valid = 1, rd = 0, wd = 0x1234 -> lsu_ready = 1; next cycle rf_we = 0; last_src = 1.
REQ-043 Both valid with rd = 7, ALU wd = 0x11, LSU wd = 0x22, pointer at ALU -> rf writes 0x11 then 0x22 on consecutive cycles.
REQ-044 Transfer accepted, then rst_n pulsed low mid-cycle before the next edge -> rf_we = 0 immediately; no write of the pending data; all outputs at reset values.
REQ-045 Hold both valid for 2^CNT_W + 3 cycles -> contention_cnt saturates at all-ones and holds.
